zpager_bank: RTL and testbench
==============================

// Module: zpager_bank
// PURPOSE
//  Parametrised ATM-style memory pager bank that replaces the per-window pager instances.
//  It holds NWIN address windows over the Z80 64K space. Each window has two register sets, chosen by dos.
//  Each window resolves to a page number and a ROM/RAM flag for zmem. Windows can instead follow Pentagon-1M mapping.
//  The block also generates DOS auto-enter/exit requests and a Z80 clock stall so the fetch is redone under the new map.
// PARAMETERS
//  NWIN      4  window count; power of 2 in 2..8; window size is 64K/NWIN; index width WB=log2(NWIN)
//  PAGEW     8  page width, 6..10; bits above [5:0] come from the extension registers
//  STALL_CYC 6  fclk cycles zclk_stall is held after a DOS switch request; 1..15
// PORTS
//  fclk          in   1           system clock
//  rst_n         in   1           asynchronous reset, active low
//  zpos,zneg     in   1           Z80 clock edge strobes (fclk domain, 1-cycle pulses)
//  za            in   16          Z80 address
//  zd            in   8           Z80 data bus (port write data)
//  mreq_n,rd_n,m1_n in 1          Z80 strobes
//  atmF7_wr      in   1           1-cycle pulse: xxF7 write; window = za[15 -: WB]
//  ext_wr        in   1           1-cycle pulse: extension write; window = za[15 -: WB]; data zd[PAGEW-7:0]
//  pager_off     in   1           1: all windows use Pentagon-1M mapping
//  pent1m_ROM    in   1           basic-ROM select (1 = 48K BASIC)
//  pent1m_page   in   6           7FFD RAM page
//  pent1m_ram0_0 in   1           RAM page 0 replaces ROM in quarter 0
//  pent1m_1m_on  in   1           enables pent1m_page[5:3]
//  dos,cpm_n     in   1           current DOS state; CP/M lock (0 blocks DOS exit)
//  page          out  NWIN*PAGEW  per-window page, window i at [i*PAGEW +: PAGEW]
//  romnram       out  NWIN        per-window 1=ROM 0=RAM
//  dos_turn_on   out  1           1-cycle pulse
//  dos_turn_off  out  1           1-cycle pulse
//  zclk_stall    out  1           stall request to zclock
// BEHAVIOUR
//  Register sets: per window, bank b (b = current dos): follow[b], rom[b], pg[b][5:0]. Per window, shared by both banks: ext[PAGEW-7:0].
//  atmF7_wr writes only bank[dos] of the addressed window:
//    follow <= zd[7]; rom <= ~zd[6]; pg <= ~zd[5:0]   (page bits are stored inverted on the bus)
//  ext_wr writes ext of the addressed window. Simultaneous atmF7_wr and ext_wr: both writes take effect.
//  Resolution for window i, quarter q = (i*4)/NWIN:
//    If pager_off=1 or follow[dos]=1, use Pentagon-1M mapping:
//      q0: ram0_0 ? RAM 0 : ROM {0,~dos,pent1m_ROM}
//      q1: RAM 5
//      q2: RAM 2
//      q3: RAM {1m_on ? pent1m_page[5:3] : 3'b0, pent1m_page[2:0]}
//    Otherwise: romnram = rom[dos]; page = {ext, pg[dos]}.
//    Page values narrower than PAGEW are zero-extended.
//  page and romnram are registered, updating every fclk, so they show 1 cycle of latency from any input change.
//  Reset values:
//    page = 0, romnram = all 1, pulses = 0, zclk_stall = 0, stall counter = 0
//    all follow = 1, rom = 1, pg = 0, ext = 0
//  DOS trap FSM, states IDLE -> SEEN -> STALL -> IDLE:
//    IDLE -> SEEN: at zpos with m1_n=0, mreq_n=0, rd_n=0, first sample of the cycle only.
//    In SEEN (one fclk), for the window w currently addressed:
//      Enter: !dos, romnram[w]=1, pent1m_ROM=1, za[13:8]==6'h3D
//        -> dos_turn_on pulse, go to STALL.
//      Exit:  dos, romnram[w]=0, cpm_n=1
//        -> dos_turn_off pulse, go to STALL.
//      Neither condition -> IDLE.
//    STALL: zclk_stall=1 for exactly STALL_CYC fclk cycles, then IDLE.
//    FSM re-arms only after mreq_n returns high.
//  Boundaries:
//    atmF7_wr during STALL still takes effect; it uses dos as sampled in that cycle.
//    Counter wraps never; it saturates at 0.
//    rst_n asserted mid-STALL: stall drops immediately and asynchronously.
//    Out-of-range window index is impossible by construction (WB bits).
// STRUCTURE
//  zpager_defs.vh: quarter page constants (RAM5, RAM2), FSM state encodings, and the WB computation macro.
//  Sub-module zpager_win: one window's two banks, ext register and resolution mux. zpager_bank generates NWIN copies plus the shared trap FSM.
// TESTING
//  1. Reset, then read all windows: romnram=4'b1111 is wrong; expect q0 ROM page 2 (dos=0, pent1m_ROM=0) and q1/q2/q3 RAM 5, 2, 0.
//  2. atmF7_wr, za=16'h7FF7, zd=8'h7A, dos=0: window1 RAM page 6'h05 one cycle later; bank1 unchanged.
//  3. PAGEW=8: ext_wr zd=2'b11 to window 3, then F7 zd=8'h40 -> page 8'hFF; pager_off=1 -> page back to pent1m.
//  4. M1 fetch at 16'h3D2F, pent1m_ROM=1, dos=0: one dos_turn_on pulse; zclk_stall high exactly 6 cycles.
//  5. dos=1, M1 from RAM window, cpm_n=0: no pulse, no stall. Same with cpm_n=1: dos_turn_off pulse and stall.
//  6. rst_n low on stall cycle 3: zclk_stall=0 asynchronously; after release, FSM in IDLE, registers at reset values.

Source files
------------

// File: rtl/zpager_bank_pkg.sv
// Shared types and constants for the ATM-style pager bank: quarter page
// constants, trap FSM states, the resolved window map and the Pentagon-1M
// mapping helper.
package zpager_bank_pkg;

    localparam int unsigned PG_LOW_W    = 6;
    localparam int unsigned STALL_CNT_W = 4;

    localparam logic [PG_LOW_W-1:0] PG_RAM0 = 6'd0;
    localparam logic [PG_LOW_W-1:0] PG_RAM5 = 6'd5;
    localparam logic [PG_LOW_W-1:0] PG_RAM2 = 6'd2;

    typedef enum logic [1:0] {
        TRAP_IDLE  = 2'd0,
        TRAP_SEEN  = 2'd1,
        TRAP_STALL = 2'd2
    } trap_state_t;

    // One window's resolved mapping: ROM flag plus low page bits.
    typedef struct packed {
        logic                rom;
        logic [PG_LOW_W-1:0] pg;
    } win_map_t;

    // Pentagon-1M mapping of a 16K quarter.
    function automatic win_map_t pent1m_map(
        input logic [1:0] quarter,
        input logic       dos,
        input logic       rom48,
        input logic       ram0_0,
        input logic       on_1m,
        input logic [5:0] page_7ffd
    );
        win_map_t m;
        m.rom = 1'b0;
        m.pg  = PG_RAM0;
        case (quarter)
            2'd0: begin
                if (!ram0_0) begin
                    m.rom = 1'b1;
                    m.pg  = {4'b0000, ~dos, rom48};
                end
            end
            2'd1: m.pg = PG_RAM5;
            2'd2: m.pg = PG_RAM2;
            default: m.pg = {(on_1m ? page_7ffd[5:3] : 3'b000), page_7ffd[2:0]};
        endcase
        return m;
    endfunction

endpackage

// File: rtl/zpager_win.sv
// One pager window: two register sets selected by dos, a shared extension
// register and the registered page/ROM resolution.
// Ports:
//   fclk, rst_n     clock, async active-low reset
//   i_f7_we         xxF7 write aimed at this window
//   i_ext_we        extension write aimed at this window
//   i_zd            Z80 data bus
//   i_dos           current DOS state (selects register set)
//   i_pager_off     force Pentagon-1M mapping
//   i_pent          Pentagon-1M mapping for this window's quarter
//   o_page          registered page number
//   o_romnram       registered 1=ROM 0=RAM
module zpager_win
    import zpager_bank_pkg::*;
#(
    parameter int unsigned PAGEW = 8
) (
    input  logic             fclk,
    input  logic             rst_n,
    input  logic             i_f7_we,
    input  logic             i_ext_we,
    input  logic [7:0]       i_zd,
    input  logic             i_dos,
    input  logic             i_pager_off,
    input  win_map_t         i_pent,
    output logic [PAGEW-1:0] o_page,
    output logic             o_romnram
);

    // A 6-bit page still keeps a 1-bit extension register; the cast below drops it.
    localparam int unsigned EXTW = (PAGEW > PG_LOW_W) ? PAGEW - PG_LOW_W : 1;

    logic [1:0]               r_follow;
    logic [1:0]               r_rom;
    logic [1:0][PG_LOW_W-1:0] r_pg;
    logic [EXTW-1:0]          r_ext;
    logic [PAGEW-1:0]         r_page;
    logic                     r_romnram;

    logic                     w_follow;
    logic [PAGEW-1:0]         w_page_nx;
    logic                     w_rom_nx;

    // Register-set writes; page bits arrive inverted on the bus.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_follow <= 2'b11;
            r_rom    <= 2'b11;
            r_pg     <= '0;
            r_ext    <= '0;
        end else begin
            if (i_f7_we) begin
                r_follow[i_dos] <= i_zd[7];
                r_rom[i_dos]    <= ~i_zd[6];
                r_pg[i_dos]     <= ~i_zd[PG_LOW_W-1:0];
            end
            if (i_ext_we) begin
                r_ext <= i_zd[EXTW-1:0];
            end
        end
    end

    // Resolution mux: own register set unless following Pentagon-1M.
    always_comb begin
        w_follow  = i_pager_off | r_follow[i_dos];
        w_page_nx = PAGEW'({r_ext, r_pg[i_dos]});
        w_rom_nx  = r_rom[i_dos];
        if (w_follow) begin
            w_page_nx = PAGEW'(i_pent.pg);
            w_rom_nx  = i_pent.rom;
        end
    end

    // Output registers, refreshed every fclk.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_page    <= '0;
            r_romnram <= 1'b1;
        end else begin
            r_page    <= w_page_nx;
            r_romnram <= w_rom_nx;
        end
    end

    assign o_page    = r_page;
    assign o_romnram = r_romnram;

endmodule

// File: rtl/zpager_bank.sv
// ATM-style pager bank: NWIN address windows over the Z80 64K space, each
// resolving to a page and ROM/RAM flag, plus the DOS auto-enter/exit trap
// that stalls the Z80 clock so the fetch repeats under the new map.
// Ports:
//   fclk, rst_n                    clock, async active-low reset
//   zpos, zneg                     Z80 clock edge strobes
//   za, zd                         Z80 address and data
//   mreq_n, rd_n, m1_n             Z80 strobes
//   atmF7_wr, ext_wr               window register write pulses
//   pager_off                      force Pentagon-1M mapping on all windows
//   pent1m_ROM/page/ram0_0/1m_on   Pentagon-1M state
//   dos, cpm_n                     DOS state, CP/M lock
//   page, romnram                  per-window mapping (registered)
//   dos_turn_on, dos_turn_off      DOS switch request pulses
//   zclk_stall                     Z80 clock stall request
module zpager_bank
    import zpager_bank_pkg::*;
#(
    parameter int unsigned NWIN      = 4,
    parameter int unsigned PAGEW     = 8,
    parameter int unsigned STALL_CYC = 6
) (
    input  logic                  fclk,
    input  logic                  rst_n,
    input  logic                  zpos,
    input  logic                  zneg,
    input  logic [15:0]           za,
    input  logic [7:0]            zd,
    input  logic                  mreq_n,
    input  logic                  rd_n,
    input  logic                  m1_n,
    input  logic                  atmF7_wr,
    input  logic                  ext_wr,
    input  logic                  pager_off,
    input  logic                  pent1m_ROM,
    input  logic [5:0]            pent1m_page,
    input  logic                  pent1m_ram0_0,
    input  logic                  pent1m_1m_on,
    input  logic                  dos,
    input  logic                  cpm_n,
    output logic [NWIN*PAGEW-1:0] page,
    output logic [NWIN-1:0]       romnram,
    output logic                  dos_turn_on,
    output logic                  dos_turn_off,
    output logic                  zclk_stall
);

    localparam int unsigned WB = $clog2(NWIN);

    logic [WB-1:0] w_win_sel;
    assign w_win_sel = za[15 -: WB];

    // Per-window instances; each sees the Pentagon-1M map of its own quarter.
    for (genvar gi = 0; gi < NWIN; gi++) begin : g_win
        localparam int unsigned QUARTER = (gi * 4) / NWIN;

        win_map_t w_pent;
        logic     w_f7_we;
        logic     w_ext_we;

        assign w_pent   = pent1m_map(2'(QUARTER), dos, pent1m_ROM,
                                     pent1m_ram0_0, pent1m_1m_on, pent1m_page);
        assign w_f7_we  = atmF7_wr && (w_win_sel == WB'(gi));
        assign w_ext_we = ext_wr   && (w_win_sel == WB'(gi));

        zpager_win #(
            .PAGEW(PAGEW)
        ) u_win (
            .fclk        (fclk),
            .rst_n       (rst_n),
            .i_f7_we     (w_f7_we),
            .i_ext_we    (w_ext_we),
            .i_zd        (zd),
            .i_dos       (dos),
            .i_pager_off (pager_off),
            .i_pent      (w_pent),
            .o_page      (page[gi*PAGEW +: PAGEW]),
            .o_romnram   (romnram[gi])
        );
    end

    // Only za[15:8] and the zpos strobe matter for trapping.
    logic w_unused;
    assign w_unused = &{1'b0, zneg, za[7:0], za[14]};

    trap_state_t            r_state;
    trap_state_t            w_state_nx;
    logic [STALL_CNT_W-1:0] r_cnt;
    logic [STALL_CNT_W-1:0] w_cnt_nx;
    logic                   r_armed;
    logic                   w_armed_nx;
    logic                   r_dos_turn_on;
    logic                   w_dos_turn_on_nx;
    logic                   r_dos_turn_off;
    logic                   w_dos_turn_off_nx;
    logic                   r_zclk_stall;
    logic                   w_zclk_stall_nx;

    logic w_sel_rom;
    logic w_fetch;
    logic w_enter;
    logic w_exit;

    assign w_sel_rom = romnram[w_win_sel];
    assign w_fetch   = zpos && !m1_n && !mreq_n && !rd_n;
    assign w_enter   = !dos && w_sel_rom && pent1m_ROM && (za[13:8] == 6'h3D);
    assign w_exit    = dos && !w_sel_rom && cpm_n;

    // Trap FSM state and registered outputs.
    always_ff @(posedge fclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= TRAP_IDLE;
            r_cnt          <= '0;
            r_armed        <= 1'b1;
            r_dos_turn_on  <= 1'b0;
            r_dos_turn_off <= 1'b0;
            r_zclk_stall   <= 1'b0;
        end else begin
            r_state        <= w_state_nx;
            r_cnt          <= w_cnt_nx;
            r_armed        <= w_armed_nx;
            r_dos_turn_on  <= w_dos_turn_on_nx;
            r_dos_turn_off <= w_dos_turn_off_nx;
            r_zclk_stall   <= w_zclk_stall_nx;
        end
    end

    // Next state: one trap per memory cycle; the arm flag reloads while mreq_n is high.
    always_comb begin
        w_state_nx        = r_state;
        w_cnt_nx          = r_cnt;
        w_armed_nx        = r_armed | mreq_n;
        w_dos_turn_on_nx  = 1'b0;
        w_dos_turn_off_nx = 1'b0;
        w_zclk_stall_nx   = 1'b0;
        case (r_state)
            TRAP_IDLE: begin
                if (w_fetch && r_armed) begin
                    w_state_nx = TRAP_SEEN;
                    w_armed_nx = 1'b0;
                end
            end
            TRAP_SEEN: begin
                if (w_enter || w_exit) begin
                    w_dos_turn_on_nx  = w_enter;
                    w_dos_turn_off_nx = w_exit;
                    w_zclk_stall_nx   = 1'b1;
                    w_cnt_nx          = STALL_CNT_W'(STALL_CYC);
                    w_state_nx        = TRAP_STALL;
                end else begin
                    w_state_nx = TRAP_IDLE;
                end
            end
            TRAP_STALL: begin
                // Counter counts down to 1 and then parks at 0.
                if (r_cnt <= STALL_CNT_W'(1)) begin
                    w_cnt_nx   = '0;
                    w_state_nx = TRAP_IDLE;
                end else begin
                    w_cnt_nx        = r_cnt - STALL_CNT_W'(1);
                    w_zclk_stall_nx = 1'b1;
                end
            end
            default: begin
                w_state_nx = TRAP_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    assign dos_turn_on  = r_dos_turn_on;
    assign dos_turn_off = r_dos_turn_off;
    assign zclk_stall   = r_zclk_stall;

endmodule

// File: tb/tb_zpager_bank.sv
// Randomised and directed bench for zpager_bank (NWIN=4, PAGEW=8, STALL_CYC=6)
// against a behavioural model of the window registers and trap rules.
module tb_zpager_bank;

    localparam int NWIN      = 4;
    localparam int PAGEW     = 8;
    localparam int STALL_CYC = 6;

    logic        fclk = 1'b0;
    logic        rst_n = 1'b0;
    logic        zpos = 1'b0, zneg = 1'b0;
    logic [15:0] za = 16'h0000;
    logic [7:0]  zd = 8'h00;
    logic        mreq_n = 1'b1, rd_n = 1'b1, m1_n = 1'b1;
    logic        atmF7_wr = 1'b0, ext_wr = 1'b0, pager_off = 1'b0;
    logic        pent1m_ROM = 1'b0, pent1m_ram0_0 = 1'b0, pent1m_1m_on = 1'b0;
    logic [5:0]  pent1m_page = 6'h00;
    logic        dos = 1'b0, cpm_n = 1'b1;
    logic [NWIN*PAGEW-1:0] page;
    logic [NWIN-1:0]       romnram;
    logic        dos_turn_on, dos_turn_off, zclk_stall;

    zpager_bank #(.NWIN(NWIN), .PAGEW(PAGEW), .STALL_CYC(STALL_CYC)) dut (
        .fclk(fclk), .rst_n(rst_n), .zpos(zpos), .zneg(zneg), .za(za), .zd(zd),
        .mreq_n(mreq_n), .rd_n(rd_n), .m1_n(m1_n), .atmF7_wr(atmF7_wr), .ext_wr(ext_wr),
        .pager_off(pager_off), .pent1m_ROM(pent1m_ROM), .pent1m_page(pent1m_page),
        .pent1m_ram0_0(pent1m_ram0_0), .pent1m_1m_on(pent1m_1m_on), .dos(dos), .cpm_n(cpm_n),
        .page(page), .romnram(romnram), .dos_turn_on(dos_turn_on),
        .dos_turn_off(dos_turn_off), .zclk_stall(zclk_stall)
    );

    always #5 fclk = ~fclk;

    int n_tests = 0;
    int n_fail  = 0;

    // Window register model: [bank][window].
    bit       m_follow [2][NWIN];
    bit       m_rom    [2][NWIN];
    bit [5:0] m_pg     [2][NWIN];
    bit [1:0] m_ext    [NWIN];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int b = 0; b < 2; b++)
            for (int i = 0; i < NWIN; i++) begin
                m_follow[b][i] = 1'b1;
                m_rom[b][i]    = 1'b1;
                m_pg[b][i]     = 6'd0;
            end
        for (int i = 0; i < NWIN; i++) m_ext[i] = 2'd0;
    endtask

    function automatic void resolve(input int i, output logic r, output logic [7:0] p);
        int q;
        q = (i * 4) / NWIN;
        r = 1'b0;
        p = 8'd0;
        if (pager_off || m_follow[dos][i]) begin
            case (q)
                0: if (!pent1m_ram0_0) begin
                       r = 1'b1;
                       p = 8'((dos ? 0 : 2) + (pent1m_ROM ? 1 : 0));
                   end
                1: p = 8'd5;
                2: p = 8'd2;
                default: p = pent1m_1m_on ? 8'(pent1m_page) : 8'(pent1m_page % 8);
            endcase
        end else begin
            r = m_rom[dos][i];
            p = 8'(m_ext[i] * 64 + m_pg[dos][i]);
        end
    endfunction

    function automatic void expect_all(output logic [31:0] ep, output logic [3:0] er);
        logic       r;
        logic [7:0] p;
        for (int i = 0; i < NWIN; i++) begin
            resolve(i, r, p);
            ep[i*8 +: 8] = p;
            er[i]        = r;
        end
    endfunction

    task automatic model_f7();
        int w;
        w = int'(za[15:14]);
        m_follow[dos][w] = zd[7];
        m_rom[dos][w]    = ~zd[6];
        m_pg[dos][w]     = ~zd[5:0];
    endtask

    // One clock: outputs follow the map as it stood before this edge's writes.
    task automatic step();
        logic [31:0] ep;
        logic [3:0]  er;
        @(posedge fclk);
        expect_all(ep, er);
        if (atmF7_wr) model_f7();
        if (ext_wr) m_ext[int'(za[15:14])] = zd[1:0];
        @(negedge fclk);
        check("page", page, ep);
        check("romnram", 32'(romnram), 32'(er));
    endtask

    task automatic do_reset();
        @(negedge fclk);
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge fclk);
        rst_n = 1'b1;
    endtask

    // Expected trap reaction to an M1 fetch at address a under the model.
    task automatic trap_expect(input logic [15:0] a, output int e_on, output int e_off);
        logic       r;
        logic [7:0] p;
        resolve(int'(a[15:14]), r, p);
        e_on  = (!dos && r && pent1m_ROM && a[13:8] == 6'h3D) ? 1 : 0;
        e_off = (dos && !r && cpm_n) ? 1 : 0;
    endtask

    // M1 fetch held for a bounded window; counts pulses and stall cycles.
    task automatic fetch(input string tag, input logic [15:0] a, input bit wr_mid);
        int e_on, e_off, n_on, n_off, n_st, first, last;
        bit wr_done;
        trap_expect(a, e_on, e_off);
        n_on = 0; n_off = 0; n_st = 0; first = -1; last = -1; wr_done = 0;
        za = a; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; zpos = 1'b1;
        for (int k = 0; k < 24; k++) begin
            @(negedge fclk);
            n_on  += int'(dos_turn_on);
            n_off += int'(dos_turn_off);
            if (zclk_stall) begin
                n_st++;
                if (first < 0) first = k;
                last = k;
            end
            zpos = (k == 12);
            atmF7_wr = 1'b0;
            if (wr_mid && !wr_done && n_st == 2) begin
                za = 16'h80F7; zd = 8'h3E; atmF7_wr = 1'b1;
                model_f7();
                wr_done = 1;
            end
        end
        zpos = 1'b0; atmF7_wr = 1'b0;
        m1_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; za = 16'h0000;
        @(negedge fclk);
        check({tag, "_on"}, 32'(n_on), 32'(e_on));
        check({tag, "_off"}, 32'(n_off), 32'(e_off));
        check({tag, "_stall"}, 32'(n_st), (e_on + e_off > 0) ? 32'(STALL_CYC) : 32'd0);
        if (n_st > 0) check({tag, "_contig"}, 32'(last - first + 1), 32'(n_st));
        if (wr_mid) check({tag, "_wr_done"}, 32'(wr_done), 32'd1);
    endtask

    initial begin
        int seen;
        model_reset();

        // Reset values while held in reset.
        repeat (2) @(negedge fclk);
        check("rst_page", page, 32'h0);
        check("rst_romnram", 32'(romnram), 32'hF);
        check("rst_ctl", {29'd0, dos_turn_on, dos_turn_off, zclk_stall}, 32'h0);

        // First resolved map after reset.
        rst_n = 1'b1;
        step();
        check("t1_page", page, 32'h00020502);
        check("t1_romnram", 32'(romnram), 32'h1);

        // F7 write to window 1, bank 0.
        za = 16'h7FF7; zd = 8'h7A; atmF7_wr = 1'b1;
        step();
        atmF7_wr = 1'b0;
        step();
        check("t2_page1", 32'(page[15:8]), 32'h05);
        check("t2_rom1", 32'(romnram[1]), 32'h0);
        dos = 1'b1; step(); step();
        dos = 1'b0; step();

        // Extension plus F7 on window 3, then pager_off.
        za = 16'hC000; zd = 8'h03; ext_wr = 1'b1;
        step();
        ext_wr = 1'b0; za = 16'hFFF7; zd = 8'h40; atmF7_wr = 1'b1;
        step();
        atmF7_wr = 1'b0;
        step();
        check("t3_page3", 32'(page[31:24]), 32'hFF);
        check("t3_rom3", 32'(romnram[3]), 32'h0);
        pent1m_page = 6'h2B; pent1m_1m_on = 1'b1; pager_off = 1'b1;
        step();
        check("t3_off_page3", 32'(page[31:24]), 32'h2B);
        pager_off = 1'b0;
        step();

        // Random register traffic and mapping inputs, no M1 fetches.
        for (int n = 0; n < 300; n++) begin
            za            = 16'($urandom);
            zd            = 8'($urandom);
            atmF7_wr      = ($urandom_range(0, 2) == 0);
            ext_wr        = ($urandom_range(0, 2) == 0);
            dos           = 1'($urandom);
            pager_off     = ($urandom_range(0, 7) == 0);
            pent1m_ROM    = 1'($urandom);
            pent1m_ram0_0 = ($urandom_range(0, 3) == 0);
            pent1m_1m_on  = 1'($urandom);
            pent1m_page   = 6'($urandom);
            mreq_n        = 1'($urandom);
            rd_n          = 1'($urandom);
            zpos          = 1'($urandom);
            zneg          = 1'($urandom);
            step();
            check("rnd_ctl", {29'd0, dos_turn_on, dos_turn_off, zclk_stall}, 32'h0);
        end
        atmF7_wr = 1'b0; ext_wr = 1'b0; zpos = 1'b0; zneg = 1'b0;
        mreq_n = 1'b1; rd_n = 1'b1;

        // Trap scenarios from a clean map.
        pager_off = 1'b0; dos = 1'b0; cpm_n = 1'b1; pent1m_ROM = 1'b1;
        pent1m_ram0_0 = 1'b0; pent1m_1m_on = 1'b0; pent1m_page = 6'h00;
        do_reset();
        step(); step();
        fetch("t4_enter", 16'h3D2F, 1'b0);
        fetch("t4_wrong_addr", 16'h3C2F, 1'b0);

        dos = 1'b1; cpm_n = 1'b0; step(); step();
        fetch("t5_cpm_lock", 16'h8000, 1'b0);
        cpm_n = 1'b1; step();
        fetch("t5_exit", 16'h8000, 1'b0);
        fetch("t5_rom_win", 16'h3D00, 1'b0);

        // F7 write landing while the clock is stalled.
        dos = 1'b0; step(); step();
        fetch("t7_enter_wr", 16'h3D2F, 1'b1);
        step(); step();
        check("t7_page2", 32'(page[23:16]), 32'h01);
        check("t7_rom2", 32'(romnram[2]), 32'h1);

        // Reset in the middle of a stall.
        za = 16'h3D2F; m1_n = 1'b0; mreq_n = 1'b0; rd_n = 1'b0; zpos = 1'b1;
        seen = 0;
        for (int k = 0; k < 20 && seen < 3; k++) begin
            @(negedge fclk);
            zpos = 1'b0;
            if (zclk_stall) seen++;
        end
        check("t6_stall_seen", 32'(seen), 32'd3);
        #2 rst_n = 1'b0;
        #1 check("t6_async_drop", 32'(zclk_stall), 32'd0);
        model_reset();
        m1_n = 1'b1; mreq_n = 1'b1; rd_n = 1'b1; za = 16'h0000;
        repeat (2) @(negedge fclk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            check("t6_idle_ctl", {29'd0, dos_turn_on, dos_turn_off, zclk_stall}, 32'h0);
        end
        fetch("t6_rearm", 16'h3D2F, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
